// File: rtl/twi_slave.sv
// TWI (I2C) target: filtered SCL/SDA oversampling, START/STOP decode, 7-bit address match, open-drain ACK/data.
// Optional macro TWI_SLV_GCALL_EN: also ACK the general-call address 0 for writes.
module twi_slave #(
    parameter int FLT_LEN = 3
) (
    input  logic       CLK_I,
    input  logic       RST_N_I,
    input  logic [6:0] SLV_ADDR_I,
    input  logic       TWI_SCL_I,
    input  logic       TWI_SDA_I,
    output logic       TWI_SDA_OEN,
    output logic [7:0] RX_DAT_O,
    output logic       RX_VLD_O,
    input  logic       RX_NACK_I,
    input  logic [7:0] TX_DAT_I,
    output logic       TX_REQ_O,
    output logic       START_O,
    output logic       STOP_O,
    output logic       BUSY_O
);

    typedef enum logic [2:0] {
        IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, WAIT_STOP
    } state_t;

    // Bit 0 carries SCL, bit 1 carries SDA through the input path.
    logic [1:0]      s1_q, s1_d, s2_q, s2_d, flt_q, flt_d, prev_q, prev_d;
    logic [1:0][2:0] cnt_q, cnt_d;

    state_t      state_q, state_d;
    logic [3:0]  bcnt_q, bcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_dat_q, rx_dat_d;
    logic        oen_q, oen_d;
    logic        rx_vld_q, rx_vld_d;
    logic        tx_req_q, tx_req_d;
    logic        start_q, start_d;
    logic        stop_q, stop_d;
    logic        busy_q, busy_d;
    logic        nack_q, nack_d;

    logic scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det;
    logic addr_ok, nack_now;

    always_comb begin
        s1_d   = {TWI_SDA_I, TWI_SCL_I};
        s2_d   = s1_q;
        prev_d = flt_q;
        flt_d  = flt_q;
        cnt_d  = '0;
        // A level change is accepted only after FLT_LEN consecutive differing samples.
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != flt_q[i]) begin
                if (cnt_q[i] == 3'(FLT_LEN - 1)) begin
                    flt_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 3'd1;
                end
            end
        end
    end

    assign scl_f     = flt_q[0];
    assign sda_f     = flt_q[1];
    assign scl_rise  = flt_q[0] & ~prev_q[0];
    assign scl_fall  = ~flt_q[0] & prev_q[0];
    assign start_det = ~sda_f & prev_q[1] & scl_f & prev_q[0];
    assign stop_det  = sda_f & ~prev_q[1] & scl_f & prev_q[0];
    assign nack_now  = rx_vld_q ? RX_NACK_I : nack_q;

    // Evaluated on the 8th address rise: shift_q[6:0] holds the address, sda_f is R/W.
`ifdef TWI_SLV_GCALL_EN
    assign addr_ok = (shift_q[6:0] == SLV_ADDR_I) || ((shift_q[6:0] == 7'h00) && !sda_f);
`else
    assign addr_ok = (shift_q[6:0] == SLV_ADDR_I);
`endif

    always_comb begin
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        oen_d    = oen_q;
        rx_dat_d = rx_dat_q;
        rx_vld_d = 1'b0;
        tx_req_d = 1'b0;
        start_d  = 1'b0;
        stop_d   = 1'b0;
        busy_d   = busy_q;
        nack_d   = nack_now;
        if (stop_det) begin
            state_d = IDLE;
            bcnt_d  = '0;
            oen_d   = 1'b1;
            stop_d  = 1'b1;
            busy_d  = 1'b0;
        end else if (start_det) begin
            state_d = ADDR;
            bcnt_d  = '0;
            oen_d   = 1'b1;
            start_d = 1'b1;
            busy_d  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_f};
                        bcnt_d  = bcnt_q + 4'd1;
                        if (bcnt_q == 4'd7 && !addr_ok) state_d = WAIT_STOP;
                    end else if (scl_fall && bcnt_q == 4'd8) begin
                        oen_d   = 1'b0;
                        state_d = ADDR_ACK;
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        bcnt_d = '0;
                        if (shift_q[0]) begin
                            tx_req_d = 1'b1;
                            shift_d  = TX_DAT_I;
                            oen_d    = TX_DAT_I[7];
                            state_d  = RD_BYTE;
                        end else begin
                            oen_d   = 1'b1;
                            state_d = WR_BYTE;
                        end
                    end
                end
                WR_BYTE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_f};
                        bcnt_d  = bcnt_q + 4'd1;
                        if (bcnt_q == 4'd7) begin
                            rx_dat_d = {shift_q[6:0], sda_f};
                            rx_vld_d = 1'b1;
                        end
                    end else if (scl_fall && bcnt_q == 4'd8) begin
                        oen_d   = nack_now;
                        state_d = WR_ACK;
                    end
                end
                WR_ACK: begin
                    if (scl_fall) begin
                        oen_d   = 1'b1;
                        bcnt_d  = '0;
                        state_d = nack_q ? WAIT_STOP : WR_BYTE;
                    end
                end
                RD_BYTE: begin
                    if (scl_rise) begin
                        bcnt_d = bcnt_q + 4'd1;
                    end else if (scl_fall) begin
                        if (bcnt_q == 4'd8) begin
                            oen_d   = 1'b1;
                            bcnt_d  = '0;
                            state_d = RD_ACK;
                        end else begin
                            shift_d = {shift_q[6:0], 1'b0};
                            oen_d   = shift_q[6];
                        end
                    end
                end
                RD_ACK: begin
                    if (scl_rise) begin
                        nack_d = sda_f;
                    end else if (scl_fall) begin
                        if (nack_q) begin
                            oen_d   = 1'b1;
                            state_d = WAIT_STOP;
                        end else begin
                            tx_req_d = 1'b1;
                            shift_d  = TX_DAT_I;
                            oen_d    = TX_DAT_I[7];
                            bcnt_d   = '0;
                            state_d  = RD_BYTE;
                        end
                    end
                end
                WAIT_STOP: oen_d = 1'b1;
                default:   state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            s1_q     <= 2'b11;
            s2_q     <= 2'b11;
            flt_q    <= 2'b11;
            prev_q   <= 2'b11;
            cnt_q    <= '0;
            state_q  <= IDLE;
            bcnt_q   <= '0;
            shift_q  <= '0;
            oen_q    <= 1'b1;
            rx_dat_q <= '0;
            rx_vld_q <= 1'b0;
            tx_req_q <= 1'b0;
            start_q  <= 1'b0;
            stop_q   <= 1'b0;
            busy_q   <= 1'b0;
            nack_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            flt_q    <= flt_d;
            prev_q   <= prev_d;
            cnt_q    <= cnt_d;
            state_q  <= state_d;
            bcnt_q   <= bcnt_d;
            shift_q  <= shift_d;
            oen_q    <= oen_d;
            rx_dat_q <= rx_dat_d;
            rx_vld_q <= rx_vld_d;
            tx_req_q <= tx_req_d;
            start_q  <= start_d;
            stop_q   <= stop_d;
            busy_q   <= busy_d;
            nack_q   <= nack_d;
        end
    end

    assign TWI_SDA_OEN = oen_q;
    assign RX_DAT_O    = rx_dat_q;
    assign RX_VLD_O    = rx_vld_q;
    assign TX_REQ_O    = tx_req_q;
    assign START_O     = start_q;
    assign STOP_O      = stop_q;
    assign BUSY_O      = busy_q;

endmodule

// File: tb/tb_twi_slave.sv
// Bench for twi_slave: a behavioural bus master drives table-driven write transactions plus read, repeated-START and reset sequences.
module tb_twi_slave;

    localparam int Q = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] slv_addr;
    logic       scl_m, sda_m;
    logic       sda_oen;
    logic [7:0] rx_dat;
    logic       rx_vld;
    logic       rx_nack;
    logic [7:0] tx_dat;
    logic       tx_req, start_p, stop_p, busy;
    logic       sda_bus;

    always #5 clk = ~clk;
    assign sda_bus = sda_m & sda_oen;

    twi_slave #(.FLT_LEN(3)) dut (
        .CLK_I(clk), .RST_N_I(rst_n), .SLV_ADDR_I(slv_addr),
        .TWI_SCL_I(scl_m), .TWI_SDA_I(sda_bus), .TWI_SDA_OEN(sda_oen),
        .RX_DAT_O(rx_dat), .RX_VLD_O(rx_vld), .RX_NACK_I(rx_nack),
        .TX_DAT_I(tx_dat), .TX_REQ_O(tx_req), .START_O(start_p),
        .STOP_O(stop_p), .BUSY_O(busy)
    );

    int checks = 0;
    int failures = 0;

    // Monotonic event counters; tests compare differences across a sequence.
    int         rx_cnt = 0, tx_cnt = 0, st_cnt = 0, sp_cnt = 0, bfall = 0, oen_low = 0;
    logic [7:0] rx_log [64];
    logic       busy_d1 = 1'b0;

    always @(negedge clk) begin
        if (rx_vld === 1'b1) begin
            rx_log[rx_cnt & 63] = rx_dat;
            rx_cnt++;
        end
        if (tx_req === 1'b1) tx_cnt++;
        if (start_p === 1'b1) st_cnt++;
        if (stop_p === 1'b1) sp_cnt++;
        if (busy_d1 && busy !== 1'b1) bfall++;
        busy_d1 = (busy === 1'b1);
        if (sda_oen === 1'b0) oen_low++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b0; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wq();
        scl_m = 1'b1; wq();
        sda_m = 1'b1; wq();
    endtask

    task automatic bit_io(input logic b, output logic r);
        sda_m = b; wq();
        scl_m = 1'b1; wq();
        r = sda_bus; wq();
        scl_m = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_io(b[i], r);
        bit_io(1'b1, ack);
    endtask

    task automatic read_bits(output logic [7:0] b);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, r);
            b[i] = r;
        end
    endtask

    typedef struct {
        logic [7:0]      addr;
        int              nb;
        logic [2:0][7:0] d;
        int              nack_idx;
        logic            exp_aack;
        logic [2:0]      exp_ack;
        int              exp_vld;
        logic [7:0]      exp_last;
    } wvec_t;

    wvec_t tv [6];

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int b_rx, b_tx, b_st, b_sp, b_bf, b_ol, n;
        logic ack, r;
        logic [7:0] rb;

        tv[0] = '{8'hA4, 2, {8'h00, 8'h81, 8'h3C}, -1, 1'b0, 3'b000, 2, 8'h81};
        tv[1] = '{8'hA6, 1, {8'h00, 8'h00, 8'h11}, -1, 1'b1, 3'b001, 0, 8'h00};
        tv[2] = '{8'hA4, 3, {8'h56, 8'h34, 8'h12},  1, 1'b0, 3'b110, 2, 8'h34};
`ifdef TWI_SLV_GCALL_EN
        tv[3] = '{8'h00, 1, {8'h00, 8'h00, 8'h77}, -1, 1'b0, 3'b000, 1, 8'h77};
`else
        tv[3] = '{8'h00, 1, {8'h00, 8'h00, 8'h77}, -1, 1'b1, 3'b001, 0, 8'h00};
`endif
        tv[4] = '{8'h01, 0, {8'h00, 8'h00, 8'h00}, -1, 1'b1, 3'b000, 0, 8'h00};
        tv[5] = '{8'hA4, 1, {8'h00, 8'h00, 8'hF0}, -1, 1'b0, 3'b000, 1, 8'hF0};

        rst_n = 1'b0; slv_addr = 7'h52; scl_m = 1'b1; sda_m = 1'b1;
        rx_nack = 1'b0; tx_dat = 8'h00;
        repeat (4) @(negedge clk);
        chk("rst_oen", sda_oen, 1);
        chk("rst_rx_dat", rx_dat, 0);
        chk("rst_strobes", {rx_vld, tx_req, start_p, stop_p}, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            b_rx = rx_cnt; b_tx = tx_cnt; b_st = st_cnt; b_sp = sp_cnt; b_ol = oen_low;
            i2c_start();
            chk($sformatf("v%0d_busy_in", v), busy, 1);
            write_byte(tv[v].addr, ack);
            chk($sformatf("v%0d_addr_ack", v), ack, tv[v].exp_aack);
            for (int j = 0; j < tv[v].nb; j++) begin
                rx_nack = (j == tv[v].nack_idx);
                write_byte(tv[v].d[j], ack);
                chk($sformatf("v%0d_data%0d_ack", v, j), ack, tv[v].exp_ack[j]);
            end
            rx_nack = 1'b0;
            i2c_stop();
            wq();
            chk($sformatf("v%0d_busy_out", v), busy, 0);
            chk($sformatf("v%0d_starts", v), st_cnt - b_st, 1);
            chk($sformatf("v%0d_stops", v), sp_cnt - b_sp, 1);
            chk($sformatf("v%0d_rx_vld_count", v), rx_cnt - b_rx, tv[v].exp_vld);
            chk($sformatf("v%0d_tx_req_count", v), tx_cnt - b_tx, 0);
            chk($sformatf("v%0d_sda_driven", v), (oen_low - b_ol) > 0, !tv[v].exp_aack);
            if (tv[v].exp_vld > 0)
                chk($sformatf("v%0d_rx_last", v), rx_log[(rx_cnt - 1) & 63], tv[v].exp_last);
        end

        // Read two bytes; master ACKs the first and NACKs the second.
        tx_dat = 8'hC3;
        b_rx = rx_cnt; b_tx = tx_cnt; b_sp = sp_cnt;
        i2c_start();
        write_byte(8'hA5, ack);
        chk("rd_addr_ack", ack, 0);
        chk("rd_tx_req_1", tx_cnt - b_tx, 1);
        read_bits(rb);
        chk("rd_byte1", rb, 8'hC3);
        tx_dat = 8'h5A;
        bit_io(1'b0, r);
        read_bits(rb);
        chk("rd_byte2", rb, 8'h5A);
        bit_io(1'b1, r);
        chk("rd_released", sda_oen, 1);
        i2c_stop();
        wq();
        chk("rd_tx_req_2", tx_cnt - b_tx, 2);
        chk("rd_no_rx_vld", rx_cnt - b_rx, 0);
        chk("rd_stop", sp_cnt - b_sp, 1);
        chk("rd_busy_out", busy, 0);

        // Write then repeated START into a read.
        tx_dat = 8'h99;
        b_rx = rx_cnt; b_tx = tx_cnt; b_st = st_cnt; b_bf = bfall;
        i2c_start();
        write_byte(8'hA4, ack);
        chk("rs_addr1_ack", ack, 0);
        write_byte(8'h10, ack);
        chk("rs_data_ack", ack, 0);
        chk("rs_no_tx_req_yet", tx_cnt - b_tx, 0);
        i2c_start();
        write_byte(8'hA5, ack);
        chk("rs_addr2_ack", ack, 0);
        chk("rs_tx_req", tx_cnt - b_tx, 1);
        read_bits(rb);
        chk("rs_read", rb, 8'h99);
        bit_io(1'b1, r);
        chk("rs_busy_held", bfall - b_bf, 0);
        chk("rs_starts", st_cnt - b_st, 2);
        i2c_stop();
        wq();
        chk("rs_rx_vld_count", rx_cnt - b_rx, 1);
        chk("rs_rx_byte", rx_log[(rx_cnt - 1) & 63], 8'h10);
        chk("rs_busy_fall", bfall - b_bf, 1);

        // Reset asserted while the address ACK is being driven.
        i2c_start();
        for (int i = 7; i >= 0; i--) bit_io(((8'hA4 >> i) & 1) != 0, r);
        sda_m = 1'b1;
        n = 0;
        while (sda_oen !== 1'b0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_ack_driven", sda_oen, 0);
        #2 rst_n = 1'b0;
        #1 chk("rst_mid_oen_async", sda_oen, 1);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_rx_dat", rx_dat, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        b_rx = rx_cnt; b_ol = oen_low; b_sp = sp_cnt;
        wq();
        scl_m = 1'b1; wq(); wq();
        scl_m = 1'b0; wq();
        write_byte(8'h3C, ack);
        chk("post_rst_ignored_ack", ack, 1);
        i2c_stop();
        wq();
        chk("post_rst_no_rx", rx_cnt - b_rx, 0);
        chk("post_rst_never_driven", oen_low - b_ol, 0);
        chk("post_rst_stop", sp_cnt - b_sp, 1);
        i2c_start();
        write_byte(8'hA4, ack);
        chk("post_rst_next_start_ack", ack, 0);
        i2c_stop();
        wq();
        chk("post_rst_idle_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
